// File: rtl/control_seq_pkg.sv
// rtl/control_seq_pkg.sv - shared encodings for the nic8 fetch/execute sequencer
// Contents: state_t (FETCH/EXEC/WAIT/HALT), IR dest/src field codes, HALT_OPCODE.
package control_seq_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      WAIT  = 2'd2,
      HALT  = 2'd3
   } state_t;

   // dest field, ir[6:4]; code 1 has no destination
   localparam logic [2:0] DST_IR  = 3'd0;
   localparam logic [2:0] DST_A   = 3'd2;
   localparam logic [2:0] DST_B   = 3'd3;
   localparam logic [2:0] DST_X   = 3'd4;
   localparam logic [2:0] DST_MEM = 3'd5;
   localparam logic [2:0] DST_Q   = 3'd6;
   localparam logic [2:0] DST_PC  = 3'd7;

   // src field, ir[2:0]; SRC_NONE leaves the bus undriven (reads 0)
   localparam logic [2:0] SRC_ROM  = 3'd0;
   localparam logic [2:0] SRC_NONE = 3'd1;
   localparam logic [2:0] SRC_A    = 3'd2;
   localparam logic [2:0] SRC_B    = 3'd3;
   localparam logic [2:0] SRC_X    = 3'd4;
   localparam logic [2:0] SRC_RAM  = 3'd5;
   localparam logic [2:0] SRC_ALU  = 3'd6;
   localparam logic [2:0] SRC_S    = 3'd7;

   localparam logic [7:0] HALT_OPCODE = 8'h01;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational IR decode into source/dest/ALU-mode/jump terms
// Inputs : ir (instruction), a_is_zero, flag_c, flag_s (jump condition sources)
// Outputs: src_* bus-driver selects, dst_* write selects, ALU mode bits,
//          uses_ram (instruction needs RAM wait states), is_halt.
// All outputs are ungated; the sequencer qualifies them with its state.
module control_decode
   import control_seq_pkg::*;
(
   input  logic [7:0] ir,
   input  logic       a_is_zero,
   input  logic       flag_c,
   input  logic       flag_s,
   output logic       src_rom,
   output logic       src_ram,
   output logic       src_a,
   output logic       src_b,
   output logic       src_x,
   output logic       src_e,
   output logic       src_s,
   output logic       dst_ir,
   output logic       dst_a,
   output logic       dst_b,
   output logic       dst_x,
   output logic       dst_mem,
   output logic       dst_q,
   output logic       dst_pc,
   output logic       do_subtract,
   output logic       do_carry_in,
   output logic       do_shift_in,
   output logic       uses_ram,
   output logic       is_halt
);

   logic [2:0] dest;
   logic [2:0] src;
   logic       jump_ok;

   assign dest = ir[6:4];
   assign src  = ir[2:0];

   assign src_rom = (src == SRC_ROM);
   assign src_a   = (src == SRC_A);
   assign src_b   = (src == SRC_B);
   assign src_x   = (src == SRC_X);
   assign src_ram = (src == SRC_RAM);
   assign src_e   = (src == SRC_ALU);
   assign src_s   = (src == SRC_S);

   // {b7,b3} picks the jump condition
   always_comb begin
      jump_ok = 1'b0;
      case ({ir[7], ir[3]})
         2'b00:   jump_ok = 1'b1;
         2'b01:   jump_ok = a_is_zero;
         2'b10:   jump_ok = flag_c;
         default: jump_ok = flag_s;
      endcase
   end

   assign dst_ir  = (dest == DST_IR);
   assign dst_a   = (dest == DST_A);
   assign dst_b   = (dest == DST_B);
   assign dst_x   = (dest == DST_X);
   // RAM-to-RAM would drive and write the RAM in the same cycle: treat as a no-op store
   assign dst_mem = (dest == DST_MEM) && !src_ram;
   assign dst_q   = (dest == DST_Q);
   assign dst_pc  = (dest == DST_PC) && jump_ok;

   assign do_subtract = ir[3];
   assign do_shift_in = ir[3];
   assign do_carry_in = ir[7];

   assign uses_ram = src_ram || (dest == DST_MEM);
   assign is_halt  = (ir == HALT_OPCODE);

endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - nic8 clocked fetch/execute control sequencer
// Parameters: RAM_WAIT (0..15 extra cycles for RAM-touching instructions),
//             COUNT_W (width of the saturating retired-instruction counter).
// Inputs : clk, reset (sync, active-high), bus_in, a_is_zero, alu_carry, alu_shift.
// Outputs: ir_q, phase, register/PC write enables, bus-driver selects,
//          ALU mode bits, flag_c/flag_s, halted, retired.
// Build option: CONTROL_SEQ_FLAGREG_EN latches ALU flags on ALU-sourced writes;
//               without it the flags follow the live ALU outputs.
module control_seq
   import control_seq_pkg::*;
#(
   parameter int RAM_WAIT = 0,
   parameter int COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         bus_in,
   input  logic               a_is_zero,
   input  logic               alu_carry,
   input  logic               alu_shift,
   output logic [7:0]         ir_q,
   output logic [1:0]         phase,
   output logic               load_ir,
   output logic               inc_pc,
   output logic               load_pc,
   output logic               load_a,
   output logic               load_b,
   output logic               load_x,
   output logic               load_q,
   output logic               store_mem,
   output logic               assert_rom,
   output logic               assert_ram,
   output logic               assert_a,
   output logic               assert_b,
   output logic               assert_x,
   output logic               assert_e,
   output logic               assert_s,
   output logic               do_subtract,
   output logic               do_carry_in,
   output logic               do_shift_in,
   output logic               flag_c,
   output logic               flag_s,
   output logic               halted,
   output logic [COUNT_W-1:0] retired
);

   state_t             state;
   logic [3:0]         wait_cnt;
   logic [7:0]         ir;
   logic [COUNT_W-1:0] count;

   logic d_src_rom, d_src_ram, d_src_a, d_src_b, d_src_x, d_src_e, d_src_s;
   logic d_dst_ir, d_dst_a, d_dst_b, d_dst_x, d_dst_mem, d_dst_q, d_dst_pc;
   logic d_sub, d_cin, d_shin, d_uses_ram, d_is_halt;

   logic fetch_st, exec_st, wait_st;
   logic needs_wait, active, complete, retire_ev;

`ifdef CONTROL_SEQ_FLAGREG_EN
   logic flag_c_q, flag_s_q;
   assign flag_c = flag_c_q;
   assign flag_s = flag_s_q;
`else
   assign flag_c = alu_carry;
   assign flag_s = alu_shift;
`endif

   control_decode u_decode (
      .ir          (ir),
      .a_is_zero   (a_is_zero),
      .flag_c      (flag_c),
      .flag_s      (flag_s),
      .src_rom     (d_src_rom),
      .src_ram     (d_src_ram),
      .src_a       (d_src_a),
      .src_b       (d_src_b),
      .src_x       (d_src_x),
      .src_e       (d_src_e),
      .src_s       (d_src_s),
      .dst_ir      (d_dst_ir),
      .dst_a       (d_dst_a),
      .dst_b       (d_dst_b),
      .dst_x       (d_dst_x),
      .dst_mem     (d_dst_mem),
      .dst_q       (d_dst_q),
      .dst_pc      (d_dst_pc),
      .do_subtract (d_sub),
      .do_carry_in (d_cin),
      .do_shift_in (d_shin),
      .uses_ram    (d_uses_ram),
      .is_halt     (d_is_halt)
   );

   assign fetch_st = !reset && (state == FETCH);
   assign exec_st  = !reset && (state == EXEC);
   assign wait_st  = !reset && (state == WAIT);

   assign needs_wait = (RAM_WAIT > 0) && d_uses_ram;
   // active: source and ALU mode are driven; complete: the dest write cycle
   assign active    = (exec_st && !d_is_halt) || wait_st;
   assign complete  = (exec_st && !d_is_halt && !needs_wait) || (wait_st && (wait_cnt == 4'd0));
   assign retire_ev = complete || (exec_st && d_is_halt);

   assign load_ir   = fetch_st || (complete && d_dst_ir);
   assign inc_pc    = fetch_st;
   assign load_pc   = complete && d_dst_pc;
   assign load_a    = complete && d_dst_a;
   assign load_b    = complete && d_dst_b;
   assign load_x    = complete && d_dst_x;
   assign load_q    = complete && d_dst_q;
   assign store_mem = complete && d_dst_mem;

   assign assert_rom = fetch_st || (active && d_src_rom);
   assign assert_ram = active && d_src_ram;
   assign assert_a   = active && d_src_a;
   assign assert_b   = active && d_src_b;
   assign assert_x   = active && d_src_x;
   assign assert_e   = active && d_src_e;
   assign assert_s   = active && d_src_s;

   assign do_subtract = active && d_sub;
   assign do_carry_in = active && d_cin;
   assign do_shift_in = active && d_shin;

   assign ir_q    = ir;
   assign phase   = state;
   assign halted  = (state == HALT);
   assign retired = count;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         wait_cnt <= 4'd0;
         ir       <= 8'h00;
         count    <= '0;
`ifdef CONTROL_SEQ_FLAGREG_EN
         flag_c_q <= 1'b0;
         flag_s_q <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               ir    <= bus_in;
               state <= EXEC;
            end
            EXEC: begin
               if (d_is_halt) begin
                  state <= HALT;
               end else if (needs_wait) begin
                  state    <= WAIT;
                  wait_cnt <= 4'(RAM_WAIT - 1);
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0)
                  wait_cnt <= wait_cnt - 4'd1;
            end
            default: ;
         endcase

         // dest=IR reloads from the bus and re-decodes without a fresh fetch
         if (complete) begin
            state <= d_dst_ir ? EXEC : FETCH;
            if (d_dst_ir)
               ir <= bus_in;
`ifdef CONTROL_SEQ_FLAGREG_EN
            if (d_src_e) begin
               flag_c_q <= alu_carry;
               flag_s_q <= alu_shift;
            end
`endif
         end

         if (retire_ev && (count != '1))
            count <= count + 1'b1;
      end
   end

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - directed self-checking bench for control_seq
// u0: RAM_WAIT=0, COUNT_W=16; u1: RAM_WAIT=3, COUNT_W=2; inputs shared.
module tb_control_seq;

   // strobe vector bit order: load_ir inc_pc load_pc load_a load_b load_x load_q store_mem
   // assert_rom assert_ram assert_a assert_b assert_x assert_e assert_s sub cin shin
   localparam logic [17:0] M_LIR  = 18'(1) << 17;
   localparam logic [17:0] M_INC  = 18'(1) << 16;
   localparam logic [17:0] M_LPC  = 18'(1) << 15;
   localparam logic [17:0] M_LA   = 18'(1) << 14;
   localparam logic [17:0] M_SM   = 18'(1) << 10;
   localparam logic [17:0] M_AROM = 18'(1) << 9;
   localparam logic [17:0] M_ARAM = 18'(1) << 8;
   localparam logic [17:0] M_AA   = 18'(1) << 7;
   localparam logic [17:0] M_AE   = 18'(1) << 4;
   localparam logic [17:0] M_SUB  = 18'(1) << 2;
   localparam logic [17:0] M_CIN  = 18'(1) << 1;
   localparam logic [17:0] M_SHI  = 18'(1) << 0;
   localparam logic [17:0] M_FETCH = M_LIR | M_INC | M_AROM;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] bus_in = 8'h00;
   logic       a_is_zero = 1'b0;
   logic       alu_carry = 1'b0;
   logic       alu_shift = 1'b0;

   wire [7:0]  ir0, ir1;
   wire [1:0]  ph0, ph1;
   wire [17:0] st0, st1;
   wire        fc0, fs0, h0, fc1, fs1, h1;
   wire [15:0] r0;
   wire [1:0]  r1;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   control_seq #(.RAM_WAIT(0), .COUNT_W(16)) u0 (
      .clk(clk), .reset(reset), .bus_in(bus_in), .a_is_zero(a_is_zero),
      .alu_carry(alu_carry), .alu_shift(alu_shift), .ir_q(ir0), .phase(ph0),
      .load_ir(st0[17]), .inc_pc(st0[16]), .load_pc(st0[15]), .load_a(st0[14]),
      .load_b(st0[13]), .load_x(st0[12]), .load_q(st0[11]), .store_mem(st0[10]),
      .assert_rom(st0[9]), .assert_ram(st0[8]), .assert_a(st0[7]), .assert_b(st0[6]),
      .assert_x(st0[5]), .assert_e(st0[4]), .assert_s(st0[3]),
      .do_subtract(st0[2]), .do_carry_in(st0[1]), .do_shift_in(st0[0]),
      .flag_c(fc0), .flag_s(fs0), .halted(h0), .retired(r0)
   );

   control_seq #(.RAM_WAIT(3), .COUNT_W(2)) u1 (
      .clk(clk), .reset(reset), .bus_in(bus_in), .a_is_zero(a_is_zero),
      .alu_carry(alu_carry), .alu_shift(alu_shift), .ir_q(ir1), .phase(ph1),
      .load_ir(st1[17]), .inc_pc(st1[16]), .load_pc(st1[15]), .load_a(st1[14]),
      .load_b(st1[13]), .load_x(st1[12]), .load_q(st1[11]), .store_mem(st1[10]),
      .assert_rom(st1[9]), .assert_ram(st1[8]), .assert_a(st1[7]), .assert_b(st1[6]),
      .assert_x(st1[5]), .assert_e(st1[4]), .assert_s(st1[3]),
      .do_subtract(st1[2]), .do_carry_in(st1[1]), .do_shift_in(st1[0]),
      .flag_c(fc1), .flag_s(fs1), .halted(h1), .retired(r1)
   );

   // leaves the bench 1 time unit into the first FETCH cycle after reset
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // from inside a FETCH cycle: present op, move 1 time unit into the EXEC cycle
   task automatic fetch_to_exec(input logic [7:0] op);
      bus_in = op;
      @(negedge clk);
      #1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_chk++; if (st0 !== 18'h0) begin n_fail++; $display("FAIL reset_strobes_u0 got %h want %h", st0, 18'h0); end
      n_chk++; if (st1 !== 18'h0) begin n_fail++; $display("FAIL reset_strobes_u1 got %h want %h", st1, 18'h0); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++; if (ph0 !== 2'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", ph0); end
      n_chk++; if (ir0 !== 8'h00) begin n_fail++; $display("FAIL reset_ir got %h want 00", ir0); end
      n_chk++; if (r0 !== 16'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", r0); end
      n_chk++; if (h0 !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", h0); end
      n_chk++; if (fc0 !== 1'b0 || fs0 !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", fc0, fs0); end
   endtask

   task automatic test_basic_exec();
      do_reset();
      n_chk++; if (st0 !== M_FETCH) begin n_fail++; $display("FAIL fetch_strobes got %h want %h", st0, M_FETCH); end
      fetch_to_exec(8'h22);
      n_chk++; if (ph0 !== 2'd1) begin n_fail++; $display("FAIL exec_phase got %0d want 1", ph0); end
      n_chk++; if (ir0 !== 8'h22) begin n_fail++; $display("FAIL exec_ir got %h want 22", ir0); end
      n_chk++; if (st0 !== (M_AA | M_LA)) begin n_fail++; $display("FAIL exec_a_to_a got %h want %h", st0, M_AA | M_LA); end
      next_cycle();
      n_chk++; if (ph0 !== 2'd0) begin n_fail++; $display("FAIL back_to_fetch got %0d want 0", ph0); end
      n_chk++; if (r0 !== 16'd1) begin n_fail++; $display("FAIL retired_one got %0d want 1", r0); end
   endtask

   task automatic test_ram_wait();
      logic [17:0] exp;
      do_reset();
      fetch_to_exec(8'h25);
      n_chk++; if (st0 !== (M_ARAM | M_LA)) begin n_fail++; $display("FAIL ram_nowait_u0 got %h want %h", st0, M_ARAM | M_LA); end
      for (int i = 0; i < 4; i++) begin
         exp = (i == 3) ? (M_ARAM | M_LA) : M_ARAM;
         n_chk++; if (st1 !== exp) begin n_fail++; $display("FAIL ram_wait_strobe c%0d got %h want %h", i + 2, st1, exp); end
         n_chk++; if (ph1 !== ((i == 0) ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL ram_wait_phase c%0d got %0d", i + 2, ph1); end
         next_cycle();
      end
      n_chk++; if (ph1 !== 2'd0 || st1 !== M_FETCH) begin n_fail++; $display("FAIL ram_wait_refetch got ph %0d st %h want ph 0 st %h", ph1, st1, M_FETCH); end
      n_chk++; if (r1 !== 2'd1) begin n_fail++; $display("FAIL ram_wait_retired got %0d want 1", r1); end
   endtask

   task automatic test_store();
      logic [17:0] exp;
      do_reset();
      fetch_to_exec(8'h52);
      n_chk++; if (st0 !== (M_AA | M_SM)) begin n_fail++; $display("FAIL store_nowait got %h want %h", st0, M_AA | M_SM); end
      for (int i = 0; i < 4; i++) begin
         exp = (i == 3) ? (M_AA | M_SM) : M_AA;
         n_chk++; if (st1 !== exp) begin n_fail++; $display("FAIL store_wait c%0d got %h want %h", i + 2, st1, exp); end
         next_cycle();
      end
      do_reset();
      fetch_to_exec(8'h55);
      n_chk++; if (st0 !== M_ARAM) begin n_fail++; $display("FAIL ram_to_ram got %h want %h", st0, M_ARAM); end
      next_cycle();
      n_chk++; if (r0 !== 16'd1) begin n_fail++; $display("FAIL ram_to_ram_retired got %0d want 1", r0); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      fetch_to_exec(8'h52);
      next_cycle();
      n_chk++; if (ph1 !== 2'd2 || st1 !== M_AA) begin n_fail++; $display("FAIL wait_entry got ph %0d st %h want ph 2 st %h", ph1, st1, M_AA); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_chk++; if (st1 !== 18'h0) begin n_fail++; $display("FAIL reset_in_wait got %h want 0", st1); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++; if (ph1 !== 2'd0 || st1 !== M_FETCH) begin n_fail++; $display("FAIL after_wait_reset got ph %0d st %h want ph 0 st %h", ph1, st1, M_FETCH); end
      fetch_to_exec(8'h22);
      n_chk++; if (st1 !== (M_AA | M_LA)) begin n_fail++; $display("FAIL post_abort_exec got %h want %h", st1, M_AA | M_LA); end
      next_cycle();
   endtask

   task automatic test_dest_ir();
      do_reset();
      fetch_to_exec(8'h00);
      bus_in = 8'h22;
      #1;
      n_chk++; if (st0 !== (M_AROM | M_LIR)) begin n_fail++; $display("FAIL dest_ir_strobes got %h want %h", st0, M_AROM | M_LIR); end
      next_cycle();
      n_chk++; if (ph0 !== 2'd1 || ir0 !== 8'h22) begin n_fail++; $display("FAIL dest_ir_redecode got ph %0d ir %h want ph 1 ir 22", ph0, ir0); end
      n_chk++; if (st0 !== (M_AA | M_LA)) begin n_fail++; $display("FAIL dest_ir_next got %h want %h", st0, M_AA | M_LA); end
      n_chk++; if (r0 !== 16'd1) begin n_fail++; $display("FAIL dest_ir_retired got %0d want 1", r0); end
      next_cycle();
   endtask

   task automatic test_flags();
      do_reset();
      alu_carry = 1'b1;
      alu_shift = 1'b1;
      fetch_to_exec(8'h26);
      n_chk++; if (st0 !== (M_AE | M_LA)) begin n_fail++; $display("FAIL alu_to_a got %h want %h", st0, M_AE | M_LA); end
      next_cycle();
`ifdef CONTROL_SEQ_FLAGREG_EN
      alu_carry = 1'b0;
      alu_shift = 1'b0;
      #1;
`endif
      n_chk++; if (fc0 !== 1'b1 || fs0 !== 1'b1) begin n_fail++; $display("FAIL flags_set got %b%b want 11", fc0, fs0); end
      fetch_to_exec(8'hF0);
      n_chk++; if (st0 !== (M_AROM | M_CIN | M_LPC)) begin n_fail++; $display("FAIL jc_taken got %h want %h", st0, M_AROM | M_CIN | M_LPC); end
      next_cycle();
      fetch_to_exec(8'hF8);
      n_chk++; if (st0 !== (M_AROM | M_SUB | M_CIN | M_SHI | M_LPC)) begin n_fail++; $display("FAIL js_taken got %h want %h", st0, M_AROM | M_SUB | M_CIN | M_SHI | M_LPC); end
      next_cycle();
      alu_carry = 1'b0;
      alu_shift = 1'b0;
      fetch_to_exec(8'h26);
      next_cycle();
      n_chk++; if (fc0 !== 1'b0) begin n_fail++; $display("FAIL flag_c_clear got %b want 0", fc0); end
      fetch_to_exec(8'hF0);
      n_chk++; if (st0 !== (M_AROM | M_CIN)) begin n_fail++; $display("FAIL jc_not_taken got %h want %h", st0, M_AROM | M_CIN); end
      next_cycle();
   endtask

   task automatic test_jump_zero();
      do_reset();
      fetch_to_exec(8'h70);
      n_chk++; if (st0 !== (M_AROM | M_LPC)) begin n_fail++; $display("FAIL jmp_uncond got %h want %h", st0, M_AROM | M_LPC); end
      next_cycle();
      a_is_zero = 1'b0;
      fetch_to_exec(8'h78);
      n_chk++; if (st0 !== (M_AROM | M_SUB | M_SHI)) begin n_fail++; $display("FAIL jz_not_taken got %h want %h", st0, M_AROM | M_SUB | M_SHI); end
      next_cycle();
      a_is_zero = 1'b1;
      fetch_to_exec(8'h78);
      n_chk++; if (st0 !== (M_AROM | M_SUB | M_SHI | M_LPC)) begin n_fail++; $display("FAIL jz_taken got %h want %h", st0, M_AROM | M_SUB | M_SHI | M_LPC); end
      next_cycle();
      a_is_zero = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      fetch_to_exec(8'h01);
      n_chk++; if (st0 !== 18'h0 || ph0 !== 2'd1) begin n_fail++; $display("FAIL halt_exec got st %h ph %0d want st 0 ph 1", st0, ph0); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus_in = 8'(32'h11 + $urandom_range(0, 200));
         #1;
         n_chk++; if (h0 !== 1'b1 || ph0 !== 2'd3) begin n_fail++; $display("FAIL halt_hold c%0d got halted %b ph %0d want 1 3", i, h0, ph0); end
         n_chk++; if (st0 !== 18'h0) begin n_fail++; $display("FAIL halt_strobes c%0d got %h want 0", i, st0); end
         n_chk++; if (r0 !== 16'd1) begin n_fail++; $display("FAIL halt_retired c%0d got %0d want 1", i, r0); end
      end
      do_reset();
      n_chk++; if (ph0 !== 2'd0 || r0 !== 16'd0 || h0 !== 1'b0) begin n_fail++; $display("FAIL halt_reset got ph %0d ret %0d halted %b want 0 0 0", ph0, r0, h0); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         fetch_to_exec(8'h22);
         next_cycle();
         if (i == 1) begin
            n_chk++; if (r1 !== 2'd2) begin n_fail++; $display("FAIL count_two got %0d want 2", r1); end
         end
      end
      n_chk++; if (r1 !== 2'd3) begin n_fail++; $display("FAIL count_saturate got %0d want 3", r1); end
      n_chk++; if (r0 !== 16'd5) begin n_fail++; $display("FAIL count_wide got %0d want 5", r0); end
   endtask

   initial begin
      test_reset();
      test_basic_exec();
      test_ram_wait();
      test_store();
      test_reset_in_wait();
      test_dest_ir();
      test_flags();
      test_jump_zero();
      test_halt();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
